// File: rtl/instruction_cache_pkg.sv
// Geometry, address split and FSM encodings shared by the instruction cache files.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_cache_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 16;

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = DATA_WIDTH - OFF_W - IDX_W;

    // Refill FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Fetch address viewed as cache fields, MSB first
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [WORD_W-1:0] word;
        logic [1:0]        byte_off;
    } fetch_addr_t;

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side and instruction-memory-side signals of the instruction cache.
// Latency: n/a (wiring only).
// Backpressure: mem_req is held until mem_gnt; fetch holds PC while miss_stall.
interface instruction_cache_if;

    logic [instruction_cache_pkg::DATA_WIDTH-1:0] fetch_addr;
    logic                                         invalidate;
    logic [instruction_cache_pkg::DATA_WIDTH-1:0] cache_in;
    logic                                         cache_valid;
    logic                                         miss_stall;
    logic                                         mem_req;
    logic [instruction_cache_pkg::DATA_WIDTH-1:0] mem_addr;
    logic                                         mem_gnt;
    logic                                         mem_rvalid;
    logic [instruction_cache_pkg::DATA_WIDTH-1:0] mem_rdata;

    // Fetch stage plus instruction memory, i.e. everything around the cache
    modport master (
        output fetch_addr, invalidate, mem_gnt, mem_rvalid, mem_rdata,
        input  cache_in, cache_valid, miss_stall, mem_req, mem_addr
    );

    // The cache itself
    modport slave (
        input  fetch_addr, invalidate, mem_gnt, mem_rvalid, mem_rdata,
        output cache_in, cache_valid, miss_stall, mem_req, mem_addr
    );

endinterface

// File: rtl/instruction_cache_tag_array.sv
// Per-line valid bits with bulk clear plus tag registers; combinational tag compare.
// Latency: hit is combinational from the lookup index/tag; updates land at the next edge.
// Backpressure: none; bulk clear takes priority over setting a valid bit.
module instruction_cache_tag_array
    import instruction_cache_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_all,
    input  logic             tag_we,
    input  logic             set_valid,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [IDX_W-1:0] look_idx,
    input  logic [TAG_W-1:0] look_tag,
    output logic             hit
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_arr [NUM_LINES];

    // Valid bits: cleared by reset or invalidate, set when a clean refill completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tags are written on the last refill word, even if the line ends up killed
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_arr[fill_idx] <= fill_tag;
        end
    end

    assign hit = valid_q[look_idx] && (tag_arr[look_idx] == look_tag);

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with one-word-per-request line refill.
// Latency: hit is combinational on fetch_addr; miss costs 1 cycle plus every memory round trip.
// Backpressure: mem_req/mem_addr hold until mem_gnt; miss_stall stays high until the line hits.
module instruction_cache
    import instruction_cache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    instruction_cache_if.slave cif
);

    fetch_addr_t       fa;
    logic [1:0]        state_q;
    logic [TAG_W-1:0]  fill_tag_q;
    logic [IDX_W-1:0]  fill_idx_q;
    logic [WORD_W-1:0] cnt_q;
    logic              kill_q;
    logic              tag_hit;
    logic              hit;
    logic              rsp_fire;
    logic              last_word;
    logic              fill_done;
    logic              set_valid;
    logic              unused_byte_off;

    logic [DATA_WIDTH-1:0] data_arr [NUM_LINES][LINE_WORDS];

    assign fa              = cif.fetch_addr;
    assign unused_byte_off = ^fa.byte_off;

    // Lookups are only trusted while no refill is in flight
    assign hit             = (state_q == ST_IDLE) && tag_hit;
    assign cif.cache_valid = hit;
    assign cif.miss_stall  = ~hit;
    assign cif.cache_in    = data_arr[fa.idx][fa.word];

    // Request address is the latched line base plus the word counter
    assign cif.mem_req  = (state_q == ST_REQ);
    assign cif.mem_addr = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};

    assign rsp_fire  = (state_q == ST_WAIT) && cif.mem_rvalid;
    assign last_word = (cnt_q == WORD_W'(LINE_WORDS - 1));
    assign fill_done = rsp_fire && last_word;
    // An invalidate landing on the final word also keeps the line invalid
    assign set_valid = fill_done && !kill_q && !cif.invalidate;

    instruction_cache_tag_array u_tag_array (
        .clk       (clk),
        .reset     (reset),
        .clear_all (cif.invalidate),
        .tag_we    (fill_done),
        .set_valid (set_valid),
        .fill_idx  (fill_idx_q),
        .fill_tag  (fill_tag_q),
        .look_idx  (fa.idx),
        .look_tag  (fa.tag),
        .hit       (tag_hit)
    );

    // Refill sequencer: latch the missing line, then request/await each word in order
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            cnt_q      <= '0;
            kill_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    kill_q <= 1'b0;
                    // A miss coinciding with invalidate is retried next cycle
                    if (!tag_hit && !cif.invalidate) begin
                        fill_tag_q <= fa.tag;
                        fill_idx_q <= fa.idx;
                        cnt_q      <= '0;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (cif.invalidate) begin
                        kill_q <= 1'b1;
                    end
                    if (cif.mem_gnt) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cif.invalidate) begin
                        kill_q <= 1'b1;
                    end
                    if (rsp_fire) begin
                        if (last_word) begin
                            kill_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + WORD_W'(1);
                            state_q <= ST_REQ;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Line data: one word written per accepted response
    always_ff @(posedge clk) begin
        if (rsp_fire) begin
            data_arr[fill_idx_q][cnt_q] <= cif.mem_rdata;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Randomised fetch/memory stimulus against a line-level cache model.
// Latency: memory grant and response delays are randomised per word.
// Backpressure: grant is withheld for several cycles to exercise request hold.
module tb_instruction_cache;

    localparam int          LW  = 4;
    localparam int          NL  = 16;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    // Model: which line currently lives at each index and whether it is valid
    bit          m_valid [NL];
    logic [31:0] m_tag   [NL];

    instruction_cache_if cif ();

    instruction_cache dut (
        .clk   (clk),
        .reset (reset),
        .cif   (cif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned line_idx(input logic [31:0] a);
        return int'((a / 32'(LW * 4)) % 32'(NL));
    endfunction

    function automatic logic [31:0] line_tag(input logic [31:0] a);
        return a / 32'(LW * 4 * NL);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[line_idx(a)] && (m_tag[line_idx(a)] == line_tag(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    // Acts as instruction memory for one line refill, entered from an IDLE miss
    task automatic refill(input logic [31:0] a, input int gdelay, input int inv_w,
                          input int rst_w, output bit aborted);
        logic [31:0] base;
        logic [31:0] held;
        bit          killed;
        int          n;
        int          d;
        int          lat;
        base    = a & ~32'(LW * 4 - 1);
        aborted = 1'b0;
        killed  = 1'b0;
        for (int w = 0; w < LW; w++) begin
            n = 0;
            do begin
                @(negedge clk); #1;
                n++;
            end while (!cif.mem_req && n < 20);
            check_eq("req_up", 32'(cif.mem_req), 32'd1);
            check_eq("req_latency", 32'(n), 32'd1);
            if (!cif.mem_req) begin
                aborted = 1'b1;
                return;
            end
            check_eq("mem_addr", cif.mem_addr, base + 32'(4 * w));
            check_eq("stall_refill", 32'(cif.miss_stall), 32'd1);
            check_eq("valid_refill", 32'(cif.cache_valid), 32'd0);
            held = cif.mem_addr;
            d = (gdelay >= 0 && w == 0) ? gdelay : int'($urandom_range(0, 2));
            for (int i = 0; i < d; i++) begin
                cif.mem_gnt    = 1'b0;
                cif.mem_rvalid = ($urandom_range(0, 3) == 0);
                cif.mem_rdata  = $urandom;
                @(negedge clk); #1;
                cif.mem_rvalid = 1'b0;
                check_eq("req_hold", 32'(cif.mem_req), 32'd1);
                check_eq("addr_hold", cif.mem_addr, held);
                check_eq("stall_hold", 32'(cif.miss_stall), 32'd1);
            end
            cif.mem_gnt = 1'b1;
            @(negedge clk); #1;
            cif.mem_gnt = 1'b0;
            check_eq("req_drop", 32'(cif.mem_req), 32'd0);
            if (w == rst_w) begin
                #2 reset = 1'b1;
                #1;
                check_eq("rst_req", 32'(cif.mem_req), 32'd0);
                check_eq("rst_valid", 32'(cif.cache_valid), 32'd0);
                check_eq("rst_stall", 32'(cif.miss_stall), 32'd1);
                check_eq("rst_addr", cif.mem_addr, 32'd0);
                model_clear();
                @(negedge clk); #1;
                check_eq("rst_hold_req", 32'(cif.mem_req), 32'd0);
                aborted = 1'b1;
                return;
            end
            if (w == inv_w) begin
                cif.invalidate = 1'b1;
                model_clear();
                killed = 1'b1;
            end
            lat = int'($urandom_range(0, 2));
            for (int i = 0; i < lat; i++) begin
                @(negedge clk); #1;
                cif.invalidate = 1'b0;
                check_eq("wait_noreq", 32'(cif.mem_req), 32'd0);
            end
            cif.mem_rvalid = 1'b1;
            cif.mem_rdata  = (base + 32'(4 * w)) ^ KEY;
            @(negedge clk); #1;
            cif.mem_rvalid = 1'b0;
            cif.invalidate = 1'b0;
            check_eq("req_after_rsp", 32'(cif.mem_req), (w < LW - 1) ? 32'd1 : 32'd0);
        end
        if (!killed) begin
            m_valid[line_idx(a)] = 1'b1;
            m_tag[line_idx(a)]   = line_tag(a);
        end
    endtask

    // Present an address; on a model miss serve refills until the model says it hits
    task automatic fetch(input logic [31:0] a, input int gdelay, input int inv_w, input int rst_w);
        bit exp_hit;
        bit aborted;
        @(negedge clk);
        cif.fetch_addr = a;
        reset          = 1'b0;
        #1;
        for (int t = 0; t < 3; t++) begin
            exp_hit = model_hit(a);
            check_eq("cache_valid", 32'(cif.cache_valid), 32'(exp_hit));
            check_eq("miss_stall", 32'(cif.miss_stall), 32'(!exp_hit));
            check_eq("idle_noreq", 32'(cif.mem_req), 32'd0);
            if (exp_hit) begin
                check_eq("cache_in", cif.cache_in, (a & ~32'd3) ^ KEY);
                return;
            end
            refill(a, (t == 0) ? gdelay : -1, (t == 0) ? inv_w : -1,
                   (t == 0) ? rst_w : -1, aborted);
            if (aborted) return;
        end
    endtask

    initial begin
        bit aborted;
        int inv_w;
        cif.fetch_addr = 32'h0;
        cif.invalidate = 1'b0;
        cif.mem_gnt    = 1'b0;
        cif.mem_rvalid = 1'b0;
        cif.mem_rdata  = 32'h0;
        model_clear();
        #1;
        check_eq("reset_valid", 32'(cif.cache_valid), 32'd0);
        check_eq("reset_stall", 32'(cif.miss_stall), 32'd1);
        check_eq("reset_req", 32'(cif.mem_req), 32'd0);
        check_eq("reset_addr", cif.mem_addr, 32'd0);

        // Cold fill of line 0, then sequential hits
        fetch(32'h0000_0000, 0, -1, -1);
        fetch(32'h0000_0004, -1, -1, -1);
        fetch(32'h0000_0008, -1, -1, -1);
        fetch(32'h0000_000C, -1, -1, -1);

        // Conflict eviction at index 0
        fetch(32'h0000_0100, -1, -1, -1);
        fetch(32'h0000_0000, -1, -1, -1);

        // Invalidate during the wait for word 2: drain, then refetch from base
        fetch(32'h0000_0208, -1, 2, -1);

        // Grant withheld for five cycles
        fetch(32'h0000_0300, 5, -1, -1);

        // Miss and invalidate in the same cycle: no request until the following cycle
        @(negedge clk);
        cif.fetch_addr = 32'h0000_0440;
        cif.invalidate = 1'b1;
        #1;
        check_eq("coinc_valid", 32'(cif.cache_valid), 32'd0);
        check_eq("coinc_req", 32'(cif.mem_req), 32'd0);
        model_clear();
        @(negedge clk);
        cif.invalidate = 1'b0;
        #1;
        check_eq("coinc_retry_req", 32'(cif.mem_req), 32'd0);
        refill(32'h0000_0440, -1, -1, -1, aborted);
        check_eq("coinc_refill", 32'(aborted), 32'd0);
        fetch(32'h0000_0444, -1, -1, -1);

        // Reset in the middle of a refill, then the previously valid line must miss
        fetch(32'h0000_0300, -1, -1, -1);
        fetch(32'h0000_03C0, -1, -1, 1);
        fetch(32'h0000_0304, -1, -1, -1);

        // Random traffic over a small address window to mix hits, misses and conflicts
        for (int k = 0; k < 60; k++) begin
            inv_w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            fetch(32'($urandom_range(0, 1023)), -1, inv_w, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
